// File: rtl/merge_sort_pkg.sv
// Shared definitions for the merge-sort sequencer: controller state encoding,
// bank geometry, the float32 word type and the pad sentinel.
package merge_sort_pkg;

  localparam int DEPTH = 16;
  localparam int DW    = 32;

  // Largest finite float32; any real input sorts at or before it.
  localparam logic [31:0] PAD_VALUE = 32'h7F7F_FFFF;

  typedef logic [DW-1:0] float32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_SORT,
    ST_WAIT,
    ST_UNLOAD
  } state_e;

endpackage

// File: rtl/merge_sort_ctrl_timeout.sv
// Watchdog for the sort-wait phase: counts cycles while the controller waits
// for the datapath, flags expiry, and keeps a sticky error until reset.
// Only instantiated when MSORT_TIMEOUT_EN is defined.
module merge_sort_ctrl_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  input  logic done_i,
  output logic expire_o,
  output logic err_o
);
  import merge_sort_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Expiry fires in the last allowed wait cycle unless the sort finishes then.
  assign expire_o = wait_i & ~done_i & (cnt_q == CNT_LAST);
  assign err_o    = err_q;

  // Counter runs only while waiting; error is sticky.
  always_comb begin
    cnt_d = '0;
    if (wait_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
    err_d = err_q | expire_o;
  end

  // Watchdog registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/merge_sort_ctrl.sv
// Sequencer for the float32 merge-sort datapath: loads a frame from the input
// stream into the register bank, pads unused entries with the sentinel,
// starts the sort, waits for completion and streams the sorted words out.
// Optional wait watchdog: define MSORT_TIMEOUT_EN.
module merge_sort_ctrl #(
  parameter int              DEPTH       = merge_sort_pkg::DEPTH,
  parameter int              DW          = merge_sort_pkg::DW,
  parameter logic [DW-1:0]   PAD_VALUE   = DW'(merge_sort_pkg::PAD_VALUE),
  parameter int              TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     bank_we,
  output logic [$clog2(DEPTH)-1:0] bank_addr,
  output logic [DW-1:0]            bank_wdata,
  input  logic [DW-1:0]            bank_rdata,
  output logic                     sort_start,
  input  logic                     sort_done,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   frame_len,
  output logic                     err
);
  import merge_sort_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LAST_IDX = LW'(DEPTH - 1);
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE      = LW'(1);

  state_e        state_q, state_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_wr;
  logic          in_hs, out_hs, last_rd, timeout_hit;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign len_wr    = frame_len_q + ONE;
  assign last_rd   = (idx_q == frame_len_q - ONE);
  assign frame_len = frame_len_q;

`ifdef MSORT_TIMEOUT_EN
  merge_sort_ctrl_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (res),
    .wait_i   (state_q == ST_WAIT),
    .done_i   (sort_done),
    .expire_o (timeout_hit),
    .err_o    (err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          if (LAST_IDX == '0) begin
            state_d = ST_SORT;
          end else if (in_last) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // A full bank ends the frame even without in_last.
        if (in_hs && (in_last || frame_len_q == LAST_IDX)) begin
          state_d = (len_wr < LEN_FULL) ? ST_PAD : ST_SORT;
        end
      end
      ST_PAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sort_done) begin
          state_d = ST_UNLOAD;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_UNLOAD: begin
        if (out_hs && last_rd) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame length and shared pad/read index next values.
  always_comb begin
    frame_len_d = frame_len_q;
    idx_d       = idx_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_hs) begin
          frame_len_d = len_wr;
          idx_d       = len_wr;
        end
      end
      ST_PAD: begin
        idx_d = idx_q + ONE;
      end
      ST_SORT: begin
        idx_d = '0;
      end
      ST_WAIT: begin
        if (!sort_done && timeout_hit) begin
          frame_len_d = '0;
          idx_d       = '0;
        end
      end
      ST_UNLOAD: begin
        if (out_hs) begin
          if (last_rd) begin
            frame_len_d = '0;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      default: begin
        frame_len_d = '0;
        idx_d       = '0;
      end
    endcase
  end

  // Frame length and index registers.
  always_ff @(posedge clk) begin
    if (res) begin
      frame_len_q <= '0;
      idx_q       <= '0;
    end else begin
      frame_len_q <= frame_len_d;
      idx_q       <= idx_d;
    end
  end

  // Output decode; everything is quiet while reset is held.
  always_comb begin
    in_ready   = 1'b0;
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    sort_start = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    if (!res) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          // Incoming words go straight into the bank in the handshake cycle.
          in_ready  = 1'b1;
          bank_we   = in_valid;
          bank_addr = frame_len_q[AW-1:0];
          if (in_valid) begin
            bank_wdata = in_data;
          end
        end
        ST_PAD: begin
          bank_we    = 1'b1;
          bank_addr  = idx_q[AW-1:0];
          bank_wdata = PAD_VALUE;
        end
        ST_SORT: begin
          sort_start = 1'b1;
        end
        ST_UNLOAD: begin
          // Read address only moves on a handshake, so data holds under stall.
          bank_addr = idx_q[AW-1:0];
          out_valid = 1'b1;
          out_data  = bank_rdata;
          out_last  = last_rd;
        end
        default: begin
          busy = (state_q != ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Directed bench for merge_sort_ctrl with a behavioural register bank and
// float32 sort datapath stand-in.
module tb_merge_sort_ctrl;

  localparam int          DEPTH = 16;
  localparam int          DW    = 32;
  localparam logic [31:0] PAD   = 32'h7F7F_FFFF;

  logic          clk = 1'b0;
  logic          res;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          bank_we;
  logic [3:0]    bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;
  logic          sort_start;
  logic          sort_done = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic [4:0]    frame_len;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]          bank [DEPTH];
  logic [DEPTH*DW-1:0]  bank_flat;
  logic [DEPTH*DW-1:0]  sorted_flat;
  int                   sort_lat = 3;
  int                   sort_dly = 0;
  int                   pad_cnt = 0;
  int                   start_cnt = 0;
  int                   lat_hits = 0;
  logic                 done_seen = 1'b0;
  logic [15:0]          snap_mask = '0;
  logic [31:0]          exp_q [DEPTH];

  always #5 clk = ~clk;

  merge_sort_ctrl #(
    .TIMEOUT_CYC (20)
  ) dut (
    .clk        (clk),
    .res        (res),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata),
    .sort_start (sort_start),
    .sort_done  (sort_done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_len  (frame_len),
    .err        (err)
  );

  // Float32 ordering key: unsigned compare of the key equals numeric order.
  function automatic logic [31:0] fkey(input logic [31:0] f);
    return f[31] ? ~f : (f | 32'h8000_0000);
  endfunction

  function automatic logic [DEPTH*DW-1:0] sort_flat(input logic [DEPTH*DW-1:0] v);
    logic [31:0] a [DEPTH];
    logic [31:0] t;
    logic [DEPTH*DW-1:0] r;
    for (int i = 0; i < DEPTH; i++) a[i] = v[i*DW +: DW];
    for (int i = 1; i < DEPTH; i++) begin
      for (int j = i; j > 0; j--) begin
        if (fkey(a[j-1]) > fkey(a[j])) begin
          t = a[j-1]; a[j-1] = a[j]; a[j] = t;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  always_comb begin
    bank_flat = '0;
    for (int i = 0; i < DEPTH; i++) bank_flat[i*DW +: DW] = bank[i];
  end
  assign sorted_flat = sort_flat(bank_flat);
  assign bank_rdata  = bank[bank_addr];

  // Bank writes plus a sort datapath that finishes sort_lat cycles after start.
  always @(posedge clk) begin
    sort_done <= 1'b0;
    if (bank_we) bank[bank_addr] <= bank_wdata;
    if (sort_dly != 0) begin
      sort_dly <= sort_dly - 1;
      if (sort_dly == 1) begin
        sort_done <= 1'b1;
        for (int i = 0; i < DEPTH; i++) bank[i] <= sorted_flat[i*DW +: DW];
      end
    end else if (sort_start && sort_lat != 0) begin
      sort_dly <= sort_lat;
    end
  end

  // Observers: pad writes, start pulses, bank image at start, first-output latency.
  always @(negedge clk) begin
    if (!res && bank_we && bank_wdata === PAD) pad_cnt <= pad_cnt + 1;
    if (sort_start) begin
      start_cnt <= start_cnt + 1;
      for (int i = 0; i < DEPTH; i++) snap_mask[i] <= (bank[i] === PAD);
    end
    done_seen <= sort_done;
    if (done_seen && out_valid) lat_hits <= lat_hits + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chkb("send_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic recv(input int n, input bit bp);
    int k;
    int cyc;
    bit stalled;
    logic [31:0] held;
    logic hl;
    k = 0; cyc = 0; stalled = 0; held = '0; hl = 1'b0;
    while (k < n && cyc < 400) begin
      out_ready = bp ? (((cyc / 2) % 2) == 1) : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (stalled) begin
          check("hold_data", out_data, held);
          chkb("hold_last", out_last, hl);
        end
        if (out_ready) begin
          check("out_data", out_data, exp_q[k]);
          chkb("out_last", out_last, k == n - 1);
          check("unload_len", {27'b0, frame_len}, 32'(n));
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = out_data;
          hl      = out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (k < n) check("recv_count", 32'(k), 32'(n));
    out_ready = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    @(negedge clk);
    while (!sort_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkb("sort_start_seen", sort_start, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa [7];
    int pad_base;
    int start_base;
    int lat_base;
    fa = '{32'hBDB851EC, 32'h3F000000, 32'h40C00000, 32'hC0400000,
           32'h41300000, 32'h41100000, 32'h408B851F};
    res = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset values while reset is held.
    @(posedge clk); #1;
    @(negedge clk);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_bank_we", bank_we, 1'b0);
    chkb("rst_sort_start", sort_start, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_out_last", out_last, 1'b0);
    chkb("rst_err", err, 1'b0);
    check("rst_bank_addr", {28'b0, bank_addr}, 32'd0);
    check("rst_bank_wdata", bank_wdata, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_frame_len", {27'b0, frame_len}, 32'd0);
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    chkb("idle_in_ready", in_ready, 1'b1);
    chkb("idle_busy", busy, 1'b0);
    @(posedge clk); #1;

    // 7-word frame with in_last.
    pad_base = pad_cnt; start_base = start_cnt; lat_base = lat_hits;
    for (int i = 0; i < 7; i++) send(fa[i], i == 6);
    exp_q[0] = 32'hC0400000; exp_q[1] = 32'hBDB851EC; exp_q[2] = 32'h3F000000;
    exp_q[3] = 32'h408B851F; exp_q[4] = 32'h40C00000; exp_q[5] = 32'h41100000;
    exp_q[6] = 32'h41300000;
    recv(7, 0);
    check("f7_pad_writes", 32'(pad_cnt - pad_base), 32'd9);
    check("f7_pad_mask", {16'b0, snap_mask}, 32'h0000_FF80);
    check("f7_start_pulses", 32'(start_cnt - start_base), 32'd1);
    check("f7_first_latency", 32'(lat_hits - lat_base), 32'd1);
    @(negedge clk);
    chkb("f7_no_extra", out_valid, 1'b0);
    chkb("f7_idle", busy, 1'b0);
    @(posedge clk); #1;

    // 16-word frame without in_last; a 17th word waits for IDLE.
    pad_base = pad_cnt;
    for (int i = 0; i < 16; i++) send(32'h4000_0000 + 32'(15 - i) * 32'h0010_0000, 1'b0);
    in_valid = 1'b1; in_data = 32'h3F000000; in_last = 1'b1;
    @(negedge clk);
    chkb("f16_held_off", in_ready, 1'b0);
    check("f16_frame_len", {27'b0, frame_len}, 32'd16);
    for (int i = 0; i < 16; i++) exp_q[i] = 32'h4000_0000 + 32'(i) * 32'h0010_0000;
    @(posedge clk); #1;
    recv(16, 0);
    check("f16_pad_writes", 32'(pad_cnt - pad_base), 32'd0);
    check("f16_pad_mask", {16'b0, snap_mask}, 32'h0000_0000);

    // 1-word frame: the held 17th word is accepted once back in IDLE.
    pad_base = pad_cnt;
    @(negedge clk);
    chkb("f1_accept_ready", in_ready, 1'b1);
    chkb("f1_no_extra", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    check("f1_frame_len", {27'b0, frame_len}, 32'd1);
    @(posedge clk); #1;
    exp_q[0] = 32'h3F000000;
    recv(1, 0);
    check("f1_pad_writes", 32'(pad_cnt - pad_base), 32'd15);
    check("f1_pad_mask", {16'b0, snap_mask}, 32'h0000_FFFE);

    // Backpressure: out_ready toggles every 2 cycles.
    send(32'h40400000, 1'b0);
    send(32'hBF800000, 1'b0);
    send(32'h00000000, 1'b0);
    send(32'h41200000, 1'b0);
    send(32'hC1200000, 1'b1);
    exp_q[0] = 32'hC1200000; exp_q[1] = 32'hBF800000; exp_q[2] = 32'h00000000;
    exp_q[3] = 32'h40400000; exp_q[4] = 32'h41200000;
    recv(5, 1);
    @(negedge clk);
    chkb("bp_no_extra", out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset while padding after a 10-word frame.
    start_base = start_cnt;
    for (int i = 0; i < 10; i++) send(32'h3F80_0000 + 32'(i), i == 9);
    @(posedge clk); #1;
    res = 1'b1;
    @(negedge clk);
    chkb("padrst_we", bank_we, 1'b0);
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    chkb("padrst_busy", busy, 1'b0);
    chkb("padrst_in_ready", in_ready, 1'b1);
    chkb("padrst_out_valid", out_valid, 1'b0);
    check("padrst_frame_len", {27'b0, frame_len}, 32'd0);
    @(posedge clk); #1;

    // Fresh 3-word frame after the abandoned one.
    pad_base = pad_cnt;
`ifndef MSORT_TIMEOUT_EN
    sort_lat = 40;
`endif
    send(32'h40000000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40400000, 1'b1);
`ifndef MSORT_TIMEOUT_EN
    wait_start();
    repeat (30) @(negedge clk);
    chkb("longwait_err", err, 1'b0);
    chkb("longwait_busy", busy, 1'b1);
    chkb("longwait_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    sort_lat = 3;
`endif
    exp_q[0] = 32'h3F800000; exp_q[1] = 32'h40000000; exp_q[2] = 32'h40400000;
    recv(3, 0);
    check("f3_pad_writes", 32'(pad_cnt - pad_base), 32'd13);
    check("f3_start_pulses", 32'(start_cnt - start_base), 32'd1);

`ifdef MSORT_TIMEOUT_EN
    // Sort never completes: watchdog expires after 20 wait cycles.
    sort_lat = 0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_start();
    repeat (20) @(negedge clk);
    chkb("to_err_before", err, 1'b0);
    chkb("to_busy_before", busy, 1'b1);
    @(negedge clk);
    chkb("to_err", err, 1'b1);
    chkb("to_idle", busy, 1'b0);
    chkb("to_in_ready", in_ready, 1'b1);
    chkb("to_out_valid", out_valid, 1'b0);
    repeat (5) @(negedge clk);
    chkb("to_err_sticky", err, 1'b1);
    chkb("to_no_unload", out_valid, 1'b0);
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    chkb("to_err_cleared", err, 1'b0);
    sort_lat = 3;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_sort_ctrl.md
Name: merge_sort_ctrl

Overview:
Sequencer for the 16-entry float32 merge-sort datapath (merge_sort_vsd). It accepts a frame of IEEE-754 single-precision words on a valid/ready stream and writes them into the datapath register bank. It pads the unused entries with the max-value sentinel, pulses the sort start, and waits for sort done. It then streams the sorted words back out on a valid/ready stream. Sits between the host-side stream fabric and the sort datapath; it is the only writer and reader of the bank.

Parameters:
DEPTH, 16, bank entries / max frame length (power of two)
DW, 32, word width (float32)
PAD_VALUE, 32'h7F7F_FFFF, sentinel written to unused entries; sorts last
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
res  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_data  in  DW  input float32 word
in_last  in  1  last word of frame
in_ready  out  1  controller accepts input word
bank_we  out  1  bank write enable
bank_addr  out  $clog2(DEPTH)  bank write/read address
bank_wdata  out  DW  bank write data
bank_rdata  in  DW  bank read data, combinational from bank_addr
sort_start  out  1  one-cycle start pulse to datapath
sort_done  in  1  datapath completion pulse/level
out_valid  out  1  sorted word valid
out_data  out  DW  sorted word
out_last  out  1  last sorted word of frame
out_ready  in  1  downstream accepts word
busy  out  1  high in any state except IDLE
frame_len  out  $clog2(DEPTH)+1  words in the current frame (1..DEPTH)
err  out  1  sort timeout flag (0 unless MSORT_TIMEOUT_EN)

Behaviour:
- Reset (res=1 at a clk edge): state=IDLE. in_ready, bank_we, sort_start, out_valid, out_last, busy and err are 0. bank_addr, bank_wdata, out_data and frame_len are 0. Reset mid-frame abandons the frame; the bank contents are not cleared.
- States: IDLE, LOAD, PAD, SORT, WAIT, UNLOAD.
- IDLE: in_ready=1. An in_valid handshake writes the word to address 0, sets frame_len=1 and moves to LOAD. If in_last is also set, it moves directly to PAD (or to SORT when DEPTH=1).
- LOAD: in_ready=1. Each handshake writes the word combinationally in that cycle (bank_we=in_valid&in_ready, bank_addr=frame_len, bank_wdata=in_data) and increments frame_len.
  - Leaves LOAD on an in_last handshake, or when the write fills address DEPTH-1.
  - A full bank forces end-of-frame; the next in_valid waits (in_ready=0) until IDLE.
  - Target is PAD if frame_len<DEPTH after the write, else SORT.
- PAD: in_ready=0. Writes PAD_VALUE to addresses frame_len..DEPTH-1, one per cycle, then moves to SORT.
- SORT: asserts sort_start for exactly one cycle, then moves to WAIT.
- WAIT: waits for sort_done=1, then moves to UNLOAD with bank_addr=0. sort_done in any other state is ignored.
- UNLOAD:
  - out_valid=1, out_data=bank_rdata, bank_addr=read index; out_last=1 when index==frame_len-1.
  - Only frame_len words are emitted; pads are never output.
  - The index advances on out_valid&out_ready.
  - A handshake on out_last returns to IDLE and clears frame_len the same cycle.
  - out_data and out_last hold stable while out_valid&!out_ready.
- Latency:
  - first output = 1 cycle after sort_done;
  - full frame = N load + (DEPTH-N) pad + 1 start + datapath + N unload cycles, with no backpressure.
- Data are passed unmodified; the controller performs no float arithmetic.

Optional Feature:
Macro MSORT_TIMEOUT_EN.
- Defined: a counter runs in WAIT. When it reaches TIMEOUT_CYC with no sort_done, err is set sticky and state returns to IDLE without unloading. err clears only on res.
- Undefined: no counter, err tied 0, WAIT has no time limit.

Decomposition:
- Shared package merge_sort_pkg holds:
  - the state enum typedef;
  - DW, DEPTH, the PAD_VALUE constant 32'h7F7F_FFFF;
  - the float32 word typedef.
- One natural sub-module: merge_sort_ctrl_timeout (watchdog counter plus sticky err), instantiated only under MSORT_TIMEOUT_EN.

Test Plan:
- 7-word frame:
  - Stimulus: BDB851EC, 3F000000, 40C00000, C0400000, 41300000, 41100000, 408B851F (last), with a behavioural sort model.
  - Required: addresses 7..15 written with 7F7F_FFFF and one sort_start pulse.
  - Output: C0400000, BDB851EC, 3F000000, 408B851F, 40C00000, 41100000, 41300000, with out_last on the 7th.
- 16-word frame without in_last: in_ready drops after word 16; no PAD cycles; 16 words out, out_last on the 16th; a 17th in_valid is held off until IDLE.
- 1-word frame 3F000000 (in_last): 15 pad writes; output is the single word 3F000000 with out_last=1; frame_len=1.
- Backpressure: toggle out_ready every 2 cycles during UNLOAD. out_data must stay stable while stalled; there is no loss or duplication.
- Reset asserted in PAD at word 10: next cycle busy=0, in_ready=1, out_valid=0. A new 3-word frame then completes correctly.
- With MSORT_TIMEOUT_EN and TIMEOUT_CYC=20 and sort_done never asserted: err=1 after 20 WAIT cycles, state IDLE, no out_valid.
